apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB requester (initiator) that drives the two-slave APB bus on PCLK.
- Accepts single read/write commands on a valid/ready command port and sequences IDLE -> SETUP -> ACCESS.
- Decodes PADDR[6] into PSELECT1/PSELECT2, honours PREADY wait states, and returns read data and error status on a one-cycle response strobe.
- A wait-state timeout guarantees the bus never hangs on an unresponsive slave.

Parameters:
ADDR_W, 7, PADDR width; MSB selects slave, low ADDR_W-1 bits index slave memory
DATA_W, 8, PWDATA/PRDATA width
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (>=1)

Ports:
PCLK  in  1  bus clock, all logic on rising edge
PRESETn  in  1  synchronous reset, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
rsp_err  out  1  PSLVER from slave or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PENABLE  out  1  APB access phase
PSELECT1  out  1  select slave 1 (PADDR[ADDR_W-1]=0)
PSELECT2  out  1  select slave 2 (PADDR[ADDR_W-1]=1)
PRDATA1, PRDATA2  in  DATA_W  per-slave read data
PREADY1, PREADY2  in  1  per-slave ready
PSLVER1, PSLVER2  in  1  per-slave error

Behaviour:
- Reset: while PRESETn=0 at a clock edge, state<=IDLE. All outputs are registered and reset to 0, except cmd_ready, which is combinational (1 in IDLE). Timeout counter is cleared.
- Reset mid-transfer: PSELECTx/PENABLE drop on the same edge. No rsp_valid is issued for the aborted command.
- IDLE:
  - cmd_ready=1; PSELECTx=0; PENABLE=0.
  - On cmd_valid=1, latch addr/write/wdata into PADDR/PWRITE/PWDATA and go to SETUP.
- SETUP (exactly 1 cycle):
  - The decoded PSELECTx=1; PENABLE=0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSELECTx=1, PENABLE=1. PADDR/PWRITE/PWDATA are held stable for the whole transfer.
  - Active PREADY/PRDATA/PSLVER are muxed from the selected slave only; the other slave's inputs are ignored.
- PREADY=1 seen in ACCESS:
  - Next edge: rsp_valid=1 for 1 cycle; rsp_err=active PSLVER; rsp_timeout=0.
  - rsp_rdata=active PRDATA on a read, 0 on a write.
  - PSELECTx=0, PENABLE=0, go to IDLE.
- Wait states:
  - Counter increments each ACCESS cycle with PREADY=0.
  - If the counter reaches TIMEOUT with PREADY still 0: abort to IDLE with rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the TIMEOUT-th cycle wins over the abort.
  - Counter clears on entry to SETUP.
- Throughput: no back-to-back transfers; one IDLE cycle between commands.
  - Minimum latency, command accept to rsp_valid: 3 edges (SETUP, ACCESS, response) with zero wait states.
- rsp_* fields hold their values until the next response; only rsp_valid pulses.
- cmd_valid while not IDLE: ignored (cmd_ready=0). The source must hold its command until cmd_ready.
- PSELECT1 and PSELECT2 are never both 1. PENABLE=1 only when a PSELECTx=1.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - default ADDR_W/DATA_W constants
  - slave-select bit index constant
- One natural sub-module, apb_slave_mux: combinational select of PREADY/PRDATA/PSLVER by latched PADDR MSB, reusable as more slaves are added.
- FSM and timeout counter stay in the top.

Test Plan:
- Write 0x5A to addr 0x05, slave 1 ready on first ACCESS cycle:
  - PSELECT1=1 for 2 cycles, PENABLE high 1 cycle, PSELECT2=0 throughout.
  - rsp_valid 3 edges after accept with rsp_err=0.
- Read addr 0x05 back with slave 1 inserting 1 wait state:
  - ACCESS lasts 2 cycles.
  - rsp_rdata=0x5A, rsp_err=0.
  - PADDR/PWRITE stable throughout.
- Read addr 0x45 (slave 2) with PRDATA2=0xC3 and PRDATA1=0xFF:
  - Only PSELECT2 asserted.
  - rsp_rdata=0xC3.
  - PREADY1 toggling has no effect.
- Write with PSLVER1=1 on the PREADY cycle -> rsp_err=1, rsp_timeout=0, FSM returns to IDLE and accepts the next command.
- Read with PREADY held 0, TIMEOUT=16:
  - Abort after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PSELECTx/PENABLE low on the response cycle.
- Assert PRESETn=0 during the second wait cycle of a read:
  - Next edge: PSELECTx=0, PENABLE=0, no rsp_valid.
  - After release, cmd_ready=1 and a fresh write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB requester bridge

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 7;
    localparam int APB_DATA_W = 8;

    // The address MSB picks the slave; the remaining bits index into it.
    function automatic int sel_bit(input int addr_w);
        return addr_w - 1;
    endfunction

    localparam int APB_SEL_BIT = sel_bit(APB_ADDR_W);

endpackage

// File: rtl/apb_slave_mux.sv
// rtl/apb_slave_mux.sv - steers the selected slave's ready/data/error back to the requester

module apb_slave_mux #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] prdata1,
    input  logic [DATA_W-1:0] prdata2,
    input  logic              pready1,
    input  logic              pready2,
    input  logic              pslverr1,
    input  logic              pslverr2,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    always_comb begin
        prdata  = sel ? prdata2  : prdata1;
        pready  = sel ? pready2  : pready1;
        pslverr = sel ? pslverr2 : pslverr1;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-command APB requester for two slaves with wait-state timeout

module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PENABLE,
    output logic              PSELECT1,
    output logic              PSELECT2,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2,
    input  logic              PSLVER1,
    input  logic              PSLVER2
);

    localparam int SEL   = sel_bit(ADDR_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] paddr_d;
    logic              pwrite_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              penable_d, psel1_d, psel2_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    logic [DATA_W-1:0] act_rdata;
    logic              act_ready, act_err;

    apb_slave_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .sel      (PADDR[SEL]),
        .prdata1  (PRDATA1),
        .prdata2  (PRDATA2),
        .pready1  (PREADY1),
        .pready2  (PREADY2),
        .pslverr1 (PSLVER1),
        .pslverr2 (PSLVER2),
        .prdata   (act_rdata),
        .pready   (act_ready),
        .pslverr  (act_err)
    );

    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = PADDR;
        pwrite_d      = PWRITE;
        pwdata_d      = PWDATA;
        penable_d     = PENABLE;
        psel1_d       = PSELECT1;
        psel2_d       = PSELECT2;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        unique case (state_q)
            IDLE: begin
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    psel1_d  = ~cmd_addr[SEL];
                    psel2_d  = cmd_addr[SEL];
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A slave completing on the last allowed cycle beats the abort.
                if (act_ready) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = act_err;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = PWRITE ? '0 : act_rdata;
                    psel1_d       = 1'b0;
                    psel2_d       = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    psel1_d       = 1'b0;
                    psel2_d       = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PENABLE     <= 1'b0;
            PSELECT1    <= 1'b0;
            PSELECT2    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            PADDR       <= paddr_d;
            PWRITE      <= pwrite_d;
            PWDATA      <= pwdata_d;
            PENABLE     <= penable_d;
            PSELECT1    <= psel1_d;
            PSELECT2    <= psel2_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge

module tb_apb_master_bridge;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [6:0] PADDR;
    logic       PWRITE, PENABLE, PSELECT1, PSELECT2;
    logic [7:0] PWDATA, PRDATA1, PRDATA2;
    logic       PREADY1, PREADY2, PSLVER1, PSLVER2;

    int checks = 0;
    int errors = 0;

    int lat, nsel1, nsel2, nen, bad, nrdy;
    logic [7:0] r_rdata, post_rdata;
    logic r_err, r_to, r_sel, r_en, r_valid_rst;
    logic post_valid, post_err, post_to;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .ADDR_W  (7),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PENABLE     (PENABLE),
        .PSELECT1    (PSELECT1),
        .PSELECT2    (PSELECT2),
        .PRDATA1     (PRDATA1),
        .PRDATA2     (PRDATA2),
        .PREADY1     (PREADY1),
        .PREADY2     (PREADY2),
        .PSLVER1     (PSLVER1),
        .PSLVER2     (PSLVER2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // The non-addressed slave always drives junk (0xFF, error, toggling ready).
    task automatic xfer(input bit wr, input logic [6:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input int waits, input bit serr, input int rst_at);
        int  acc;
        bit  tgt;
        bit  rdy;
        acc = 0;
        tgt = addr[6];
        lat = -1; nsel1 = 0; nsel2 = 0; nen = 0; bad = 0; nrdy = 0;
        r_sel = 1'b0; r_en = 1'b0; r_valid_rst = 1'b0;
        PRDATA1 = tgt ? 8'hFF : rd;
        PRDATA2 = tgt ? rd : 8'hFF;
        PSLVER1 = tgt;
        PSLVER2 = !tgt;
        PREADY1 = 1'b0;
        PREADY2 = 1'b0;
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                cmd_valid = 1'b0; cmd_write = !wr; cmd_addr = ~addr; cmd_wdata = ~wd;
            end
            if (rst_at != 0 && c == rst_at + 1) begin
                r_sel = PSELECT1 | PSELECT2;
                r_en = PENABLE;
                r_valid_rst = rsp_valid;
                break;
            end
            if (rsp_valid) begin
                lat = c;
                r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
                r_sel = PSELECT1 | PSELECT2; r_en = PENABLE;
                break;
            end
            if (cmd_ready) nrdy++;
            if (PSELECT1) nsel1++;
            if (PSELECT2) nsel2++;
            if (PSELECT1 && PSELECT2) bad++;
            if (PENABLE && !(PSELECT1 || PSELECT2)) bad++;
            if ((PSELECT1 || PSELECT2) &&
                (PADDR != addr || PWRITE != wr || (wr && PWDATA != wd))) bad++;
            if (PENABLE) begin
                nen++;
                acc++;
            end
            rdy = PENABLE && (acc > waits);
            PREADY1 = tgt ? c[0] : rdy;
            PREADY2 = tgt ? rdy : c[0];
            if (tgt) PSLVER2 = serr && rdy;
            else     PSLVER1 = serr && rdy;
            if (c == rst_at) PRESETn = 1'b0;
        end
        PREADY1 = 1'b0; PREADY2 = 1'b0; PSLVER1 = 1'b0; PSLVER2 = 1'b0;
        if (lat >= 0) begin
            @(negedge PCLK);
            post_valid = rsp_valid; post_rdata = rsp_rdata;
            post_err = rsp_err; post_to = rsp_timeout;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA1 = '0; PRDATA2 = '0; PREADY1 = 1'b0; PREADY2 = 1'b0;
        PSLVER1 = 1'b0; PSLVER2 = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel1", PSELECT1, 0);
        check("rst_psel2", PSELECT2, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // write 0x5A to 0x05, no wait states
        xfer(1'b1, 7'h05, 8'h5A, 8'hA5, 0, 1'b0, 0);
        check("wr_latency", lat, 3);
        check("wr_psel1_cycles", nsel1, 2);
        check("wr_psel2_cycles", nsel2, 0);
        check("wr_penable_cycles", nen, 1);
        check("wr_rsp_err", r_err, 0);
        check("wr_rsp_timeout", r_to, 0);
        check("wr_rsp_rdata", r_rdata, 8'h00);
        check("wr_bus_rules", bad, 0);
        check("wr_busy_ready", nrdy, 0);
        check("wr_rsp_pulse", post_valid, 0);
        @(negedge PCLK);

        // read 0x05 back with one wait state
        xfer(1'b0, 7'h05, 8'h00, 8'h5A, 1, 1'b0, 0);
        check("rd1_latency", lat, 4);
        check("rd1_penable_cycles", nen, 2);
        check("rd1_rsp_rdata", r_rdata, 8'h5A);
        check("rd1_rsp_err", r_err, 0);
        check("rd1_bus_rules", bad, 0);
        check("rd1_psel2_cycles", nsel2, 0);
        check("rd1_rdata_held", post_rdata, 8'h5A);

        // read 0x45 from slave 2
        xfer(1'b0, 7'h45, 8'h00, 8'hC3, 0, 1'b0, 0);
        check("rd2_latency", lat, 3);
        check("rd2_psel1_cycles", nsel1, 0);
        check("rd2_psel2_cycles", nsel2, 2);
        check("rd2_rsp_rdata", r_rdata, 8'hC3);
        check("rd2_rsp_err", r_err, 0);
        check("rd2_bus_rules", bad, 0);

        // slave error on the completing cycle, then a follow-up command
        xfer(1'b1, 7'h12, 8'h33, 8'h77, 0, 1'b1, 0);
        check("err_latency", lat, 3);
        check("err_rsp_err", r_err, 1);
        check("err_rsp_timeout", r_to, 0);
        check("err_rsp_rdata", r_rdata, 8'h00);
        check("err_err_held", post_err, 1);
        xfer(1'b0, 7'h12, 8'h00, 8'h9C, 0, 1'b0, 0);
        check("after_err_latency", lat, 3);
        check("after_err_rdata", r_rdata, 8'h9C);
        check("after_err_rsp_err", r_err, 0);

        // ready on the 16th access cycle beats the timeout
        xfer(1'b0, 7'h20, 8'h00, 8'h66, 15, 1'b0, 0);
        check("edge_latency", lat, 18);
        check("edge_penable_cycles", nen, 16);
        check("edge_rsp_timeout", r_to, 0);
        check("edge_rsp_err", r_err, 0);
        check("edge_rsp_rdata", r_rdata, 8'h66);

        // unresponsive slave: abort after 16 access cycles
        xfer(1'b0, 7'h21, 8'h00, 8'h44, 1000, 1'b0, 0);
        check("to_latency", lat, 18);
        check("to_penable_cycles", nen, 16);
        check("to_rsp_err", r_err, 1);
        check("to_rsp_timeout", r_to, 1);
        check("to_rsp_rdata", r_rdata, 8'h00);
        check("to_psel_on_rsp", r_sel, 0);
        check("to_penable_on_rsp", r_en, 0);
        check("to_bus_rules", bad, 0);
        check("to_timeout_held", post_to, 1);
        check("to_rsp_pulse", post_valid, 0);

        // reset during the second wait cycle of a read
        xfer(1'b0, 7'h07, 8'h00, 8'h11, 1000, 1'b0, 3);
        check("rst_mid_psel", r_sel, 0);
        check("rst_mid_penable", r_en, 0);
        check("rst_mid_rsp_valid", r_valid_rst, 0);
        @(negedge PCLK);
        check("rst_mid_rsp_valid_hold", rsp_valid, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        xfer(1'b1, 7'h46, 8'hE7, 8'h00, 0, 1'b0, 0);
        check("post_rst_latency", lat, 3);
        check("post_rst_psel2_cycles", nsel2, 2);
        check("post_rst_rsp_err", r_err, 0);
        check("post_rst_bus_rules", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
